instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the byte-address width of the RAM port and pc.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 fetch_req  in  1  one-cycle request to fetch the instruction at pc.
REQ-005 pc  in  ADDR_W  byte address of the instruction, sampled with fetch_req.
REQ-006 ram_rd  out  1  byte read request to RAM.
REQ-007 ram_addr  out  ADDR_W  byte address of the current read.
REQ-008 ram_ready  in  1  RAM accepts the read in any cycle where ram_rd and ram_ready are both 1.
REQ-009 ram_rdata  in  8  read data, valid exactly one cycle after acceptance.
REQ-010 ir  out  32  assembled instruction word; feeds the instruction decoder.
REQ-011 ir_valid  out  1  level; ir holds a complete instruction.
REQ-012 busy  out  1  a fetch is in progress.
REQ-013 fault  out  1  level; last request had a misaligned pc.

Function
REQ-014 FSM states SHALL be IDLE, REQ, CAP; bytes tracked by a 2-bit index k.
REQ-015 IDLE + fetch_req + pc[1:0]==0 SHALL latch pc, clear k, ir_valid and fault, and go to REQ.
REQ-016 IDLE + fetch_req + pc[1:0]!=0 SHALL set fault, clear ir_valid, leave ir unchanged, issue no RAM read, and stay in IDLE.
REQ-017 In REQ, ram_rd SHALL be 1 and ram_addr SHALL be latched pc + k, modulo 2^ADDR_W.
REQ-018 REQ SHALL stay in REQ while ram_ready==0, with ram_addr held stable.
REQ-019 REQ with ram_ready==1 SHALL go to CAP.
REQ-020 In CAP, ram_rd SHALL be 0 and ram_rdata SHALL be written to ir byte lane 3-k (big-endian: the byte at pc goes to ir[31:24], the opcode).
REQ-021 CAP with k<3 SHALL increment k and return to REQ.
REQ-022 CAP with k==3 SHALL go to IDLE and set ir_valid on the same edge.
REQ-023 ir_valid SHALL stay 1 until the next accepted fetch_req or rst.
REQ-024 ir SHALL change only in CAP or on reset.
REQ-025 busy SHALL be 1 exactly when the state is not IDLE.
REQ-026 fetch_req while busy SHALL be ignored, with no restart, no latch of pc and no fault.
REQ-027 With ram_ready held at 1, ir_valid SHALL rise on the 8th rising edge after the edge that samples fetch_req.
REQ-028 ram_rd SHALL never be asserted in IDLE or CAP.

Reset
REQ-029 rst SHALL force IDLE, k=0, ir=0, ir_valid=0, fault=0, ram_rd=0, ram_addr=0 and busy=0.
REQ-030 rst mid-fetch SHALL abandon the fetch; the following cycle SHALL show ram_rd=0, and late ram_rdata SHALL be ignored.
REQ-031 rst SHALL take priority over fetch_req in the same cycle.

Structure
REQ-032 The state enum (IDLE/REQ/CAP) and the constant FETCH_BYTES=4 SHALL live in a new shared package pkg_fetch.
REQ-033 No sub-module is required; the FSM, byte counter, address adder and ir shift/lane register are a single module.

Verification
REQ-034 pc=0x0100, RAM holds 0x11,0x23,0x40,0x00 from 0x0100, ram_ready=1 -> reads at 0x0100..0x0103, ir=0x11234000, ir_valid on the 8th edge.
REQ-035 Same as REQ-034 with ram_ready=0 for 3 cycles before byte 1 -> ram_addr held at 0x0101 while stalled, ir identical, ir_valid 3 cycles later.
REQ-036 pc=0x0102 -> fault=1, zero ram_rd pulses, ir unchanged, ir_valid=0; then pc=0x0104 -> fault cleared on acceptance.
REQ-037 ADDR_W=16, pc=0xFFFC -> addresses 0xFFFC..0xFFFF, no overflow into bit 16.
REQ-038 Second fetch_req at pc=0x0200 during a fetch of pc=0x0100 -> ignored, ir from 0x0100 only.
REQ-039 rst after byte 2 is captured -> next cycle idle outputs (busy=0, ir=0); a new fetch at 0x0000 completes normally.

Source files
------------

// File: rtl/pkg_fetch.sv
`default_nettype none
// ============================================================================
// Module : pkg_fetch
// Brief  : Shared definitions for the instruction fetch unit: FSM state
//          encoding and the number of bytes per instruction word.
// Rev    : 1.0 - initial release
// ============================================================================
package pkg_fetch;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2
  } fetch_state_t;

  localparam int FETCH_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch
// Brief  : Fetches one 32-bit instruction as four byte reads from a RAM with
//          a ready handshake and assembles it big-endian into ir. A pc that
//          is not word aligned is rejected with a fault flag.
// Rev    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import pkg_fetch::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ready,
  input  logic [7:0]        ram_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic              busy,
  output logic              fault
);

  localparam logic [1:0] LAST_K = 2'(FETCH_BYTES - 1);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] base;
  logic [1:0]        k;
  logic              aligned_req;

  // Only an aligned request seen while idle starts a fetch.
  assign aligned_req = fetch_req && (pc[1:0] == 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one REQ/CAP pair per byte, back to IDLE after the last.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aligned_req) state_nxt = REQ;
      REQ:     if (ram_ready)   state_nxt = CAP;
      CAP:     state_nxt = (k == LAST_K) ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch base address, byte index, instruction lanes and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= '0;
      k        <= 2'd0;
      ir       <= 32'd0;
      ir_valid <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_req) begin
            ir_valid <= 1'b0;
            if (aligned_req) begin
              base  <= pc;
              k     <= 2'd0;
              fault <= 1'b0;
            end else begin
              fault <= 1'b1;
            end
          end
        end
        CAP: begin
          // Byte at the lowest address lands in the top lane (opcode byte).
          case (k)
            2'd0:    ir[31:24] <= ram_rdata;
            2'd1:    ir[23:16] <= ram_rdata;
            2'd2:    ir[15:8]  <= ram_rdata;
            default: ir[7:0]   <= ram_rdata;
          endcase
          if (k == LAST_K) begin
            ir_valid <= 1'b1;
          end else begin
            k <= k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM request only in REQ; the address wraps naturally at 2^ADDR_W.
  assign ram_rd   = (state == REQ);
  assign ram_addr = ram_rd ? (base + ADDR_W'(k)) : '0;
  assign busy     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Directed self-checking bench for instr_fetch with a byte RAM
//          model and address / instruction scoreboards.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] pc = 16'h0;
  logic        ram_rd;
  logic [15:0] ram_addr;
  logic        ram_ready = 1'b1;
  logic [7:0]  ram_rdata = 8'h00;
  logic [31:0] ir;
  logic        ir_valid;
  logic        busy;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  logic prev_valid = 1'b0;

  logic [7:0]  mem [logic [15:0]];
  logic [15:0] exp_addr [$];
  logic [31:0] exp_ir [$];

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_ready(ram_ready),
    .ram_rdata(ram_rdata), .ir(ir), .ir_valid(ir_valid),
    .busy(busy), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_mem(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // RAM model: data one cycle after acceptance, junk otherwise.
  always @(posedge clk) begin
    if (ram_rd && ram_ready) ram_rdata <= rd_mem(ram_addr);
    else                     ram_rdata <= 8'hA5;
  end

  // Monitor: accepted read addresses and completed instructions.
  always @(negedge clk) begin
    if (ram_rd) rd_cycles++;
    if (!rst && ram_rd && ram_ready) begin
      if (exp_addr.size() == 0) check("unexpected_read", {16'h0, ram_addr}, 32'hFFFF_FFFF);
      else check("read_addr", {16'h0, ram_addr}, {16'h0, exp_addr.pop_front()});
    end
    if (ir_valid && !prev_valid) begin
      if (exp_ir.size() == 0) check("unexpected_valid", ir, 32'hFFFF_FFFF);
      else check("ir_word", ir, exp_ir.pop_front());
    end
    prev_valid = ir_valid;
  end

  task automatic push_fetch(input logic [15:0] a, input logic [31:0] word);
    for (int i = 0; i < 4; i++) exp_addr.push_back(a + 16'(i));
    exp_ir.push_back(word);
  endtask

  task automatic start_fetch(input logic [15:0] a);
    @(posedge clk); #1;
    fetch_req = 1'b1;
    pc = a;
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ir_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n;
  int rd_before;

  initial begin
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h23; mem[16'h0102] = 8'h40; mem[16'h0103] = 8'h00;
    mem[16'h0104] = 8'h55; mem[16'h0105] = 8'h66; mem[16'h0106] = 8'h77; mem[16'h0107] = 8'h88;
    mem[16'hFFFC] = 8'hDE; mem[16'hFFFD] = 8'hAD; mem[16'hFFFE] = 8'hBE; mem[16'hFFFF] = 8'hEF;
    mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h02; mem[16'h0002] = 8'h03; mem[16'h0003] = 8'h04;
    mem[16'h0200] = 8'h99;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_valid", {31'h0, ir_valid}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_rd", {31'h0, ram_rd}, 32'h0);
    check("rst_addr", {16'h0, ram_addr}, 32'h0);
    rst = 1'b0;

    // Basic fetch, ready held high: valid on the 8th edge
    push_fetch(16'h0100, 32'h1123_4000);
    start_fetch(16'h0100);
    check("busy_during", {31'h0, busy}, 32'h1);
    wait_valid(n);
    check("latency_basic", n, 32'd8);
    check("ir_basic", ir, 32'h1123_4000);
    check("idle_busy", {31'h0, busy}, 32'h0);

    // Stall three cycles before byte 1
    push_fetch(16'h0100, 32'h1123_4000);
    start_fetch(16'h0100);                 // after edge 0
    @(posedge clk); @(posedge clk); #1;   // after edge 2: REQ, k=1
    ram_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", {16'h0, ram_addr}, 32'h0101);
      check("stall_rd", {31'h0, ram_rd}, 32'h1);
      @(posedge clk); #1;
    end
    ram_ready = 1'b1;
    wait_valid(n);
    check("latency_stall", n + 5, 32'd11);
    check("ir_stall", ir, 32'h1123_4000);

    // Misaligned pc: fault, no reads, ir unchanged
    rd_before = rd_cycles;
    start_fetch(16'h0102);
    repeat (3) @(posedge clk);
    #1;
    check("mis_fault", {31'h0, fault}, 32'h1);
    check("mis_valid", {31'h0, ir_valid}, 32'h0);
    check("mis_ir", ir, 32'h1123_4000);
    check("mis_busy", {31'h0, busy}, 32'h0);
    check("mis_reads", rd_cycles - rd_before, 32'd0);

    // Aligned fetch clears fault on acceptance
    push_fetch(16'h0104, 32'h5566_7788);
    start_fetch(16'h0104);
    check("fault_clear", {31'h0, fault}, 32'h0);
    wait_valid(n);
    check("latency_0104", n, 32'd8);

    // Top of address space: no carry past bit 15
    push_fetch(16'hFFFC, 32'hDEAD_BEEF);
    start_fetch(16'hFFFC);
    wait_valid(n);
    check("ir_wrap", ir, 32'hDEAD_BEEF);

    // Request while busy is ignored
    push_fetch(16'h0100, 32'h1123_4000);
    start_fetch(16'h0100);
    @(posedge clk); #1;
    fetch_req = 1'b1;
    pc = 16'h0200;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    check("busy_req_fault", {31'h0, fault}, 32'h0);
    wait_valid(n);
    check("latency_ignore", n + 2, 32'd8);
    check("ir_ignore", ir, 32'h1123_4000);

    // Reset after byte 2 captured abandons the fetch
    for (int i = 0; i < 3; i++) exp_addr.push_back(16'h0100 + 16'(i));
    start_fetch(16'h0100);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_ir", ir, 32'h0);
    check("abort_rd", {31'h0, ram_rd}, 32'h0);
    check("abort_addr", {16'h0, ram_addr}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("late_data_ir", ir, 32'h0);
    check("late_data_valid", {31'h0, ir_valid}, 32'h0);
    exp_addr.delete();

    push_fetch(16'h0000, 32'h0102_0304);
    start_fetch(16'h0000);
    wait_valid(n);
    check("latency_0000", n, 32'd8);
    check("ir_0000", ir, 32'h0102_0304);

    repeat (2) @(posedge clk);
    #1;
    check("addr_queue_empty", exp_addr.size(), 32'd0);
    check("ir_queue_empty", exp_ir.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
